// File: rtl/lat_meas_pkg.sv
// ============================================================================
// lat_meas_pkg: shared FSM state encoding and timing constants for the
// display-latency trial sequencer.   Rev 1.0
// ============================================================================
`default_nettype none

package lat_meas_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CLEAR       = 3'd1,
    ARM         = 3'd2,
    WAIT_DONE   = 3'd3,
    CAPTURE     = 3'd4,
    GAP         = 3'd5,
    FINISH      = 3'd6,
    CLEAR_ABORT = 3'd7
  } lat_state_e;

  localparam int unsigned CLEAR_LEN          = 2;
  localparam int unsigned DEF_TRIAL_W        = 8;
  localparam int unsigned DEF_SUM_W          = 40;
  localparam int unsigned DEF_GAP_CYCLES     = 148_500_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 297_000_000;

  // Terminal value of a 0-based 32-bit timer that spans 'cycles' cycles.
  function automatic logic [31:0] last_tick(input int unsigned cycles);
    return 32'(cycles - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/latency_meas_sequencer_if.sv
// ============================================================================
// latency_meas_sequencer_if: clear/start/done/delay handshake between the
// sequencer (master) and the video pattern generator (slave).   Rev 1.0
// ============================================================================
`default_nettype none

interface latency_meas_sequencer_if;
  logic        clear_out;
  logic        start_out;
  logic        done_in;
  logic [31:0] delay_in;

  modport master (
    output clear_out,
    output start_out,
    input  done_in,
    input  delay_in
  );

  modport slave (
    input  clear_out,
    input  start_out,
    output done_in,
    output delay_in
  );
endinterface

`default_nettype wire

// File: rtl/lat_stats_accum.sv
// ============================================================================
// lat_stats_accum: last/sum/success-count statistics over captured delays;
// min/max tracking exists only when LAT_MINMAX_EN is defined.   Rev 1.0
// ============================================================================
`default_nettype none

module lat_stats_accum
  import lat_meas_pkg::*;
#(
  parameter int unsigned TRIAL_W = DEF_TRIAL_W,
  parameter int unsigned SUM_W   = DEF_SUM_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clr_i,
  input  logic               cap_i,
  input  logic [31:0]        delay_i,
  output logic [31:0]        last_o,
  output logic [SUM_W-1:0]   sum_o,
  output logic [TRIAL_W-1:0] ok_cnt_o
`ifdef LAT_MINMAX_EN
  ,
  output logic [31:0]        min_o,
  output logic [31:0]        max_o
`endif
);

  localparam logic [TRIAL_W-1:0] CNT_ONE = {{(TRIAL_W-1){1'b0}}, 1'b1};

  logic [31:0]        last_q;
  logic [SUM_W-1:0]   sum_q;
  logic [TRIAL_W-1:0] ok_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST || clr_i) begin
      last_q   <= '0;
      sum_q    <= '0;
      ok_cnt_q <= '0;
    end else if (cap_i) begin
      last_q   <= delay_i;
      sum_q    <= sum_q + {{(SUM_W-32){1'b0}}, delay_i};
      ok_cnt_q <= ok_cnt_q + CNT_ONE;
    end
  end

  assign last_o   = last_q;
  assign sum_o    = sum_q;
  assign ok_cnt_o = ok_cnt_q;

`ifdef LAT_MINMAX_EN
  logic [31:0] min_q;
  logic [31:0] max_q;

  // min starts at all-ones so the first capture always replaces it.
  always_ff @(posedge CLK) begin
    if (RST || clr_i) begin
      min_q <= 32'hFFFF_FFFF;
      max_q <= '0;
    end else if (cap_i) begin
      if (delay_i < min_q) min_q <= delay_i;
      if (delay_i > max_q) max_q <= delay_i;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
`endif

endmodule

`default_nettype wire

// File: rtl/latency_meas_sequencer.sv
// ============================================================================
// latency_meas_sequencer: runs N clear/start/done latency trials against the
// pattern generator and accumulates statistics. Optional: LAT_MINMAX_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module latency_meas_sequencer
  import lat_meas_pkg::*;
#(
  parameter int unsigned TRIAL_W        = DEF_TRIAL_W,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned SUM_W          = DEF_SUM_W
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       run_in,
  input  logic                       abort_in,
  input  logic [TRIAL_W-1:0]         num_trials_in,
  latency_meas_sequencer_if.master   gen,
  output logic                       busy_out,
  output logic                       result_valid_out,
  output logic [TRIAL_W-1:0]         trial_idx_out,
  output logic [TRIAL_W-1:0]         ok_cnt_out,
  output logic [TRIAL_W-1:0]         timeout_cnt_out,
  output logic [31:0]                last_out,
  output logic [SUM_W-1:0]           sum_out
`ifdef LAT_MINMAX_EN
  ,
  output logic [31:0]                min_out,
  output logic [31:0]                max_out
`endif
);

  localparam logic [31:0]        CLR_LAST = last_tick(CLEAR_LEN);
  localparam logic [31:0]        GAP_LAST = last_tick(GAP_CYCLES);
  localparam logic [31:0]        TO_LAST  = last_tick(TIMEOUT_CYCLES);
  localparam logic [TRIAL_W:0]   IDX_ONE  = {{TRIAL_W{1'b0}}, 1'b1};
  localparam logic [TRIAL_W-1:0] CNT_ONE  = {{(TRIAL_W-1){1'b0}}, 1'b1};

  lat_state_e         state_q;
  logic [31:0]        timer_q;
  logic [TRIAL_W-1:0] n_q;
  logic [TRIAL_W-1:0] trial_idx_q;
  logic [TRIAL_W-1:0] timeout_cnt_q;
  logic               clear_q;
  logic               start_q;
  logic               busy_q;
  logic               result_valid_q;

  logic [TRIAL_W:0]   trial_idx_d;
  logic               more_trials;
  logic               run_accept;
  logic               abort_hit;
  logic               stats_clr;
  logic               stats_cap;

  assign trial_idx_d = {1'b0, trial_idx_q} + IDX_ONE;
  assign more_trials = trial_idx_d < {1'b0, n_q};
  assign run_accept  = (state_q == IDLE) && run_in && (num_trials_in != '0);
  // CLEAR_ABORT is excluded so a held abort level still ends in IDLE.
  assign abort_hit   = abort_in && (state_q != IDLE) && (state_q != CLEAR_ABORT);
  assign stats_clr   = run_accept;
  assign stats_cap   = (state_q == CAPTURE) && !abort_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      n_q            <= '0;
      trial_idx_q    <= '0;
      timeout_cnt_q  <= '0;
      clear_q        <= 1'b0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else if (abort_hit) begin
      state_q <= CLEAR_ABORT;
      clear_q <= 1'b1;
      start_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run_accept) begin
            state_q        <= CLEAR;
            n_q            <= num_trials_in;
            trial_idx_q    <= '0;
            timeout_cnt_q  <= '0;
            timer_q        <= '0;
            clear_q        <= 1'b1;
            busy_q         <= 1'b1;
            result_valid_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (timer_q == CLR_LAST) begin
            state_q <= ARM;
            clear_q <= 1'b0;
            start_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        ARM: begin
          state_q <= WAIT_DONE;
          timer_q <= '0;
        end
        WAIT_DONE: begin
          if (gen.done_in) begin
            state_q <= CAPTURE;
          end else if (timer_q == TO_LAST) begin
            timeout_cnt_q <= timeout_cnt_q + CNT_ONE;
            trial_idx_q   <= trial_idx_d[TRIAL_W-1:0];
            timer_q       <= '0;
            state_q       <= more_trials ? GAP : FINISH;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        CAPTURE: begin
          trial_idx_q <= trial_idx_d[TRIAL_W-1:0];
          timer_q     <= '0;
          state_q     <= more_trials ? GAP : FINISH;
        end
        GAP: begin
          if (timer_q == GAP_LAST) begin
            state_q <= CLEAR;
            timer_q <= '0;
            clear_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        FINISH: begin
          state_q        <= IDLE;
          busy_q         <= 1'b0;
          result_valid_q <= 1'b1;
        end
        CLEAR_ABORT: begin
          state_q <= IDLE;
          clear_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          clear_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Delay settles one cycle after done, so it is sampled during CAPTURE.
  lat_stats_accum #(
    .TRIAL_W (TRIAL_W),
    .SUM_W   (SUM_W)
  ) u_stats (
    .CLK      (CLK),
    .RST      (RST),
    .clr_i    (stats_clr),
    .cap_i    (stats_cap),
    .delay_i  (gen.delay_in),
    .last_o   (last_out),
    .sum_o    (sum_out),
    .ok_cnt_o (ok_cnt_out)
`ifdef LAT_MINMAX_EN
    ,
    .min_o    (min_out),
    .max_o    (max_out)
`endif
  );

  assign gen.clear_out       = clear_q;
  assign gen.start_out       = start_q;
  assign busy_out            = busy_q;
  assign result_valid_out    = result_valid_q;
  assign trial_idx_out       = trial_idx_q;
  assign timeout_cnt_out     = timeout_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_latency_meas_sequencer.sv
// ============================================================================
// tb_latency_meas_sequencer: directed bench with a pattern-generator model
// that raises done K cycles after start and presents delay K a cycle later.
// ============================================================================
`default_nettype none

module tb_latency_meas_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        run_in = 1'b0;
  logic        abort_in = 1'b0;
  logic [7:0]  num_trials_in = '0;
  logic        busy_out, result_valid_out;
  logic [7:0]  trial_idx_out, ok_cnt_out, timeout_cnt_out;
  logic [31:0] last_out;
  logic [39:0] sum_out;
`ifdef LAT_MINMAX_EN
  logic [31:0] min_out, max_out;
`endif

  int n_chk = 0;
  int n_pass = 0;

  latency_meas_sequencer_if gif ();

  latency_meas_sequencer #(
    .TRIAL_W        (8),
    .GAP_CYCLES     (10),
    .TIMEOUT_CYCLES (100),
    .SUM_W          (40)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .run_in           (run_in),
    .abort_in         (abort_in),
    .num_trials_in    (num_trials_in),
    .gen              (gif.master),
    .busy_out         (busy_out),
    .result_valid_out (result_valid_out),
    .trial_idx_out    (trial_idx_out),
    .ok_cnt_out       (ok_cnt_out),
    .timeout_cnt_out  (timeout_cnt_out),
    .last_out         (last_out),
`ifdef LAT_MINMAX_EN
    .min_out          (min_out),
    .max_out          (max_out),
`endif
    .sum_out          (sum_out)
  );

  always #5 CLK = ~CLK;

  // Generator model; K=0 means done never rises.
  int  k_list [8];
  int  k_ptr = 0;
  int  cur_k = 0;
  int  gcnt = 0;
  bit  armed = 0;
  bit  pend = 0;
  initial begin
    gif.done_in  = 1'b0;
    gif.delay_in = 32'd0;
  end
  always @(negedge CLK) begin
    if (gif.clear_out) begin
      gif.done_in = 1'b0; gif.delay_in = 32'd0; armed = 0; pend = 0;
    end else if (gif.start_out) begin
      cur_k = k_list[k_ptr];
      if (k_ptr < 7) k_ptr++;
      armed = 1; gcnt = 0; gif.done_in = 1'b0; gif.delay_in = 32'h0000_0BAD;
    end else if (pend) begin
      gif.delay_in = 32'(cur_k); pend = 0;
    end else if (armed) begin
      gcnt++;
      if (gcnt == cur_k) begin gif.done_in = 1'b1; pend = 1; armed = 0; end
    end
  end

  // Start/clear monitor: counts starts and checks each start follows a 2-cycle clear.
  int starts = 0;
  int bad_seq = 0;
  int clr_run = 0;
  int clr_cycles = 0;
  always @(negedge CLK) begin
    if (gif.start_out) begin
      starts++;
      if (clr_run != 2) bad_seq++;
    end
    if (gif.clear_out) begin clr_run++; clr_cycles++; end
    else clr_run = 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_run(input logic [7:0] n);
    @(negedge CLK); run_in = 1'b1; num_trials_in = n;
    @(negedge CLK); run_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!busy_out) begin expired = 1'b0; break; end
    end
  endtask

  task automatic set_k(input int a, input int b, input int c);
    k_list[0] = a; k_list[1] = b; k_list[2] = c;
    for (int i = 3; i < 8; i++) k_list[i] = c;
    k_ptr = 0;
  endtask

  task automatic test_reset;
    int c0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_chk++; if (busy_out !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_out); else n_pass++;
    n_chk++; if (result_valid_out !== 1'b0) $display("FAIL rst_rv: got %b want 0", result_valid_out); else n_pass++;
    n_chk++; if (sum_out !== 40'd0 || last_out !== 32'd0) $display("FAIL rst_stats: sum %0d last %0d want 0 0", sum_out, last_out); else n_pass++;
    n_chk++; if (ok_cnt_out !== 8'd0 || timeout_cnt_out !== 8'd0 || trial_idx_out !== 8'd0)
      $display("FAIL rst_cnts: ok %0d to %0d idx %0d want 0 0 0", ok_cnt_out, timeout_cnt_out, trial_idx_out); else n_pass++;
`ifdef LAT_MINMAX_EN
    n_chk++; if (min_out !== 32'hFFFF_FFFF || max_out !== 32'd0) $display("FAIL rst_minmax: min %h max %h want ffffffff 0", min_out, max_out); else n_pass++;
`endif
    c0 = clr_cycles;
    abort_in = 1'b1;
    repeat (10) @(negedge CLK);
    abort_in = 1'b0;
    @(negedge CLK);
    n_chk++; if (clr_cycles != c0 || starts != 0) $display("FAIL idle_quiet: clear cycles %0d starts %0d want %0d 0", clr_cycles, starts, c0); else n_pass++;
    n_chk++; if (busy_out !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy_out); else n_pass++;
  endtask

  task automatic test_three_trials;
    bit exp_to;
    set_k(20, 30, 40);
    starts = 0; bad_seq = 0;
    pulse_run(8'd3);
    n_chk++; if (gif.clear_out !== 1'b1 || busy_out !== 1'b1) $display("FAIL lat_c1: clear %b busy %b want 1 1", gif.clear_out, busy_out); else n_pass++;
    @(negedge CLK);
    n_chk++; if (gif.clear_out !== 1'b1 || gif.start_out !== 1'b0) $display("FAIL lat_c2: clear %b start %b want 1 0", gif.clear_out, gif.start_out); else n_pass++;
    @(negedge CLK);
    n_chk++; if (gif.start_out !== 1'b1 || gif.clear_out !== 1'b0) $display("FAIL lat_c3: start %b clear %b want 1 0", gif.start_out, gif.clear_out); else n_pass++;
    wait_idle(2000, exp_to);
    n_chk++; if (exp_to !== 1'b0) $display("FAIL n3_done: busy never dropped, got expired=%b want 0", exp_to); else n_pass++;
    n_chk++; if (result_valid_out !== 1'b1) $display("FAIL n3_rv: got %b want 1", result_valid_out); else n_pass++;
    n_chk++; if (sum_out !== 40'd90) $display("FAIL n3_sum: got %0d want 90", sum_out); else n_pass++;
    n_chk++; if (last_out !== 32'd40) $display("FAIL n3_last: got %0d want 40", last_out); else n_pass++;
    n_chk++; if (ok_cnt_out !== 8'd3 || timeout_cnt_out !== 8'd0) $display("FAIL n3_cnts: ok %0d to %0d want 3 0", ok_cnt_out, timeout_cnt_out); else n_pass++;
    n_chk++; if (trial_idx_out !== 8'd3) $display("FAIL n3_idx: got %0d want 3", trial_idx_out); else n_pass++;
    n_chk++; if (starts != 3 || bad_seq != 0) $display("FAIL n3_seq: starts %0d badseq %0d want 3 0", starts, bad_seq); else n_pass++;
`ifdef LAT_MINMAX_EN
    n_chk++; if (min_out !== 32'd20 || max_out !== 32'd40) $display("FAIL n3_minmax: min %0d max %0d want 20 40", min_out, max_out); else n_pass++;
`endif
  endtask

  task automatic test_timeout;
    bit exp_to;
    set_k(0, 0, 0);
    starts = 0;
    pulse_run(8'd2);
    wait_idle(1000, exp_to);
    n_chk++; if (exp_to !== 1'b0) $display("FAIL to_done: expired=%b want 0", exp_to); else n_pass++;
    n_chk++; if (timeout_cnt_out !== 8'd2 || ok_cnt_out !== 8'd0) $display("FAIL to_cnts: to %0d ok %0d want 2 0", timeout_cnt_out, ok_cnt_out); else n_pass++;
    n_chk++; if (sum_out !== 40'd0 || last_out !== 32'd0) $display("FAIL to_stats: sum %0d last %0d want 0 0", sum_out, last_out); else n_pass++;
    n_chk++; if (result_valid_out !== 1'b1 || trial_idx_out !== 8'd2) $display("FAIL to_rv: rv %b idx %0d want 1 2", result_valid_out, trial_idx_out); else n_pass++;
    n_chk++; if (starts != 2) $display("FAIL to_starts: got %0d want 2", starts); else n_pass++;
`ifdef LAT_MINMAX_EN
    n_chk++; if (min_out !== 32'hFFFF_FFFF || max_out !== 32'd0) $display("FAIL to_minmax: min %h max %h want ffffffff 0", min_out, max_out); else n_pass++;
`endif
  endtask

  task automatic test_abort;
    bit seen;
    set_k(30, 30, 30);
    starts = 0;
    pulse_run(8'd5);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (starts == 2) begin seen = 1'b1; break; end
    end
    n_chk++; if (seen !== 1'b1) $display("FAIL ab_reach: second start seen=%b want 1", seen); else n_pass++;
    repeat (5) @(negedge CLK);
    abort_in = 1'b1;
    @(negedge CLK);
    abort_in = 1'b0;
    n_chk++; if (gif.clear_out !== 1'b1 || busy_out !== 1'b1) $display("FAIL ab_clr: clear %b busy %b want 1 1", gif.clear_out, busy_out); else n_pass++;
    @(negedge CLK);
    n_chk++; if (gif.clear_out !== 1'b0 || busy_out !== 1'b0) $display("FAIL ab_idle: clear %b busy %b want 0 0", gif.clear_out, busy_out); else n_pass++;
    repeat (40) @(negedge CLK);
    n_chk++; if (starts != 2 || busy_out !== 1'b0) $display("FAIL ab_stay: starts %0d busy %b want 2 0", starts, busy_out); else n_pass++;
    n_chk++; if (result_valid_out !== 1'b0 || trial_idx_out !== 8'd1) $display("FAIL ab_res: rv %b idx %0d want 0 1", result_valid_out, trial_idx_out); else n_pass++;
    n_chk++; if (ok_cnt_out !== 8'd1 || sum_out !== 40'd30) $display("FAIL ab_hold: ok %0d sum %0d want 1 30", ok_cnt_out, sum_out); else n_pass++;
  endtask

  task automatic test_run_ignored;
    bit exp_to;
    int s0;
    s0 = starts;
    pulse_run(8'd0);
    n_chk++; if (busy_out !== 1'b0 || gif.clear_out !== 1'b0) $display("FAIL n0_ign: busy %b clear %b want 0 0", busy_out, gif.clear_out); else n_pass++;
    repeat (5) @(negedge CLK);
    n_chk++; if (starts != s0 || ok_cnt_out !== 8'd1) $display("FAIL n0_hold: starts %0d ok %0d want %0d 1", starts, ok_cnt_out, s0); else n_pass++;
    set_k(15, 15, 15);
    starts = 0;
    pulse_run(8'd2);
    repeat (8) @(negedge CLK);
    pulse_run(8'd4);
    wait_idle(1000, exp_to);
    repeat (20) @(negedge CLK);
    n_chk++; if (exp_to !== 1'b0 || busy_out !== 1'b0) $display("FAIL busy_run_done: expired %b busy %b want 0 0", exp_to, busy_out); else n_pass++;
    n_chk++; if (starts != 2 || trial_idx_out !== 8'd2) $display("FAIL busy_run_cnt: starts %0d idx %0d want 2 2", starts, trial_idx_out); else n_pass++;
    n_chk++; if (ok_cnt_out !== 8'd2 || sum_out !== 40'd30 || last_out !== 32'd15)
      $display("FAIL busy_run_stats: ok %0d sum %0d last %0d want 2 30 15", ok_cnt_out, sum_out, last_out); else n_pass++;
    n_chk++; if (result_valid_out !== 1'b1) $display("FAIL busy_run_rv: got %b want 1", result_valid_out); else n_pass++;
  endtask

  task automatic test_boundary;
    bit exp_to;
    set_k(100, 100, 100);
    pulse_run(8'd1);
    wait_idle(500, exp_to);
    n_chk++; if (exp_to !== 1'b0) $display("FAIL b99_done: expired %b want 0", exp_to); else n_pass++;
    n_chk++; if (ok_cnt_out !== 8'd1 || timeout_cnt_out !== 8'd0) $display("FAIL b99_cnts: ok %0d to %0d want 1 0", ok_cnt_out, timeout_cnt_out); else n_pass++;
    n_chk++; if (sum_out !== 40'd100 || last_out !== 32'd100) $display("FAIL b99_stats: sum %0d last %0d want 100 100", sum_out, last_out); else n_pass++;
    set_k(101, 101, 101);
    pulse_run(8'd1);
    wait_idle(500, exp_to);
    repeat (5) @(negedge CLK);
    n_chk++; if (timeout_cnt_out !== 8'd1 || ok_cnt_out !== 8'd0) $display("FAIL b100_cnts: to %0d ok %0d want 1 0", timeout_cnt_out, ok_cnt_out); else n_pass++;
    n_chk++; if (sum_out !== 40'd0 || result_valid_out !== 1'b1) $display("FAIL b100_res: sum %0d rv %b want 0 1", sum_out, result_valid_out); else n_pass++;
  endtask

  task automatic test_rst_mid;
    int c0;
    set_k(50, 50, 50);
    pulse_run(8'd3);
    repeat (10) @(negedge CLK);
    c0 = clr_cycles;
    RST = 1'b1;
    @(negedge CLK);
    n_chk++; if (busy_out !== 1'b0 || gif.clear_out !== 1'b0 || gif.start_out !== 1'b0)
      $display("FAIL rstmid_ctl: busy %b clear %b start %b want 0 0 0", busy_out, gif.clear_out, gif.start_out); else n_pass++;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_chk++; if (clr_cycles != c0 || trial_idx_out !== 8'd0 || result_valid_out !== 1'b0)
      $display("FAIL rstmid_state: clear cycles %0d idx %0d rv %b want %0d 0 0", clr_cycles, trial_idx_out, result_valid_out, c0); else n_pass++;
  endtask

  initial begin
    set_k(0, 0, 0);
    test_reset;
    test_three_trials;
    test_timeout;
    test_abort;
    test_run_ignored;
    test_boundary;
    test_rst_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
